// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg: register map, register bit positions and transmitter FSM encoding
package uart_tx_dev_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 1;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO with explicit occupancy count; a pop frees room for a same-cycle push
module uart_tx_fifo
    import uart_tx_dev_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [BYTE_W-1:0]            din,
    output logic [BYTE_W-1:0]            dout,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [BYTE_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_wr, do_rd;

    assign full  = count_q[AW];
    assign empty = count_q == '0;
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next storage, pointers (wrap naturally at the power-of-two depth) and occupancy
    always_comb begin
        mem_d = mem_q;
        if (do_wr) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_rd};
        count_d  = count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with TX FIFO, programmable baud divisor and drain IRQ
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int               FIFO_DEPTH = 8,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  baud_q, baud_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  reload;
    logic              en_q, en_d;
    logic              im_q, im_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;
    logic [BYTE_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic              wr_data, wr_ctrl, wr_status, wr_div;
    logic              push, pop, tick, busy;
    logic [31:0]       status, ctrl;
    logic              unused_bits;

    assign unused_bits = ^{Addr[31:4], Din};

    assign wr_data   = WE && Addr[3:2] == REG_DATA;
    assign wr_ctrl   = WE && Addr[3:2] == REG_CTRL;
    assign wr_status = WE && Addr[3:2] == REG_STATUS;
    assign wr_div    = WE && Addr[3:2] == REG_DIV;

    assign push   = wr_data;
    assign pop    = state_q == IDLE && en_q && !fifo_empty;
    assign tick   = baud_q == '0;
    assign reload = (div_q == '0) ? '0 : div_q - 1'b1;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (Din[BYTE_W-1:0]),
        .dout (fifo_dout),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Control/divisor writes, sticky overflow (a same-cycle pop makes room, so no overflow) and IRQ condition
    always_comb begin
        en_d  = wr_ctrl ? Din[CTRL_EN] : en_q;
        im_d  = wr_ctrl ? Din[CTRL_IM] : im_q;
        div_d = wr_div ? Din[DIV_W-1:0] : div_q;
        ovf_d = wr_status ? 1'b0 : ovf_q | (push & fifo_full & ~pop);
        irq_d = im_q & fifo_empty & ~busy;
    end

    // Next FSM state: every non-idle state advances on a baud tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && bit_cnt_q == 3'd7) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Baud counter reload on frame start and every tick; shift register and bit index advance per data bit
    always_comb begin
        baud_d    = (pop || tick) ? reload : busy ? baud_q - 1'b1 : baud_q;
        shift_d   = pop ? fifo_dout : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
        bit_cnt_d = pop ? 3'd0 : (state_q == DATA && tick) ? bit_cnt_q + 3'd1 : bit_cnt_q;
    end

    // Line output and busy flag decoded from the current state
    always_comb begin
        busy = state_q != IDLE;
        tx   = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
    end

    // Combinational read mux over the four registers
    always_comb begin
        status                 = '0;
        status[ST_EMPTY]       = fifo_empty;
        status[ST_FULL]        = fifo_full;
        status[ST_BUSY]        = busy;
        status[ST_OVF]         = ovf_q;
        status[ST_COUNT +: CW] = fifo_count;
        ctrl                   = '0;
        ctrl[CTRL_EN]          = en_q;
        ctrl[CTRL_IM]          = im_q;
        Dout = (Addr[3:2] == REG_CTRL)   ? ctrl :
               (Addr[3:2] == REG_STATUS) ? status :
               (Addr[3:2] == REG_DIV)    ? {{(32-DIV_W){1'b0}}, div_q} : 32'd0;
    end

    assign IRQ = irq_q;

    // State register; asynchronous reset aborts any frame in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            baud_q    <= '0;
            div_q     <= DIV_RESET;
            en_q      <= 1'b0;
            im_q      <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            en_q      <= en_d;
            im_q      <= im_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

endmodule
